// File: rtl/ifu_fetch_queue_pkg.sv
// rtl/ifu_fetch_queue_pkg.sv - shared constants and FSM state type for the fetch queue
package ifu_pkg;

  localparam logic [4:0]  EXC_ADEL      = 5'd4;
  localparam logic [31:0] DEF_RESET_PC  = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_ENTRY = 32'h0000_4180;

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/ifu_fetch_queue_if.sv
// rtl/ifu_fetch_queue_if.sv - head-of-queue handshake between fetch unit and decode
interface ifu_fetch_queue_if #(
  parameter int PC_W = 32
);

  logic            out_valid;
  logic            out_ready;
  logic [PC_W-1:0] out_pc;
  logic [PC_W-1:0] out_instr;
  logic            out_exc;

  modport master (
    output out_valid,
    output out_pc,
    output out_instr,
    output out_exc,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_pc,
    input  out_instr,
    input  out_exc,
    output out_ready
  );

endinterface

// File: rtl/ifu_fetch_queue_fifo.sv
// rtl/ifu_fetch_queue_fifo.sv - circular buffer with synchronous clear
module ifu_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && reset && !clear) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/ifu_fetch_queue.sv
// rtl/ifu_fetch_queue.sv - fetch PC owner with decoupling queue, redirect and AdEL detection
module ifu_fetch_queue
  import ifu_pkg::*;
#(
  parameter int              PC_W      = 32,
  parameter int              DEPTH     = 4,
  parameter logic [PC_W-1:0] RESET_PC  = PC_W'(DEF_RESET_PC),
  parameter logic [PC_W-1:0] EXC_ENTRY = PC_W'(DEF_EXC_ENTRY),
  parameter logic [PC_W-1:0] IM_BASE   = PC_W'(32'h0000_3000),
  parameter int              IM_WORDS  = 4096
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   int_req,
  input  logic                   eret,
  input  logic [PC_W-1:0]        epc,
  input  logic                   redirect_valid,
  input  logic [PC_W-1:0]        redirect_pc,
  output logic [PC_W-1:0]        im_addr,
  input  logic [PC_W-1:0]        im_rdata,
  ifu_fetch_queue_if.master      fq,
  output logic [$clog2(DEPTH):0] count
);

  localparam int              CW      = $clog2(DEPTH) + 1;
  localparam int              EW      = 2 * PC_W + 1;
  localparam logic [PC_W-1:0] IM_SPAN = PC_W'(4 * IM_WORDS);
  localparam logic [PC_W-1:0] IM_LAST = IM_BASE + IM_SPAN - PC_W'(4);

  fetch_state_e    state, next_state;
  logic [PC_W-1:0] fpc, fpc_next;
  logic [PC_W-1:0] flush_target;
  logic            flush;
  logic            bad;
  logic            deq;
  logic            enq;
  logic [EW-1:0]   wdata;
  logic [EW-1:0]   head;

  assign flush        = int_req | eret | redirect_valid;
  assign flush_target = int_req ? EXC_ENTRY : (eret ? epc : redirect_pc);
  assign bad          = (fpc[1:0] != 2'b00) || (fpc < IM_BASE) || (fpc > IM_LAST);

  assign fq.out_valid = (count != '0) && !flush;
  assign deq          = fq.out_valid && fq.out_ready;
  assign enq          = (state == FETCH) && !flush && ((count < CW'(DEPTH)) || deq);

  // A bad fetch still occupies a slot so decode sees the AdEL in program order.
  assign wdata = bad ? {fpc, {PC_W{1'b0}}, 1'b1} : {fpc, im_rdata, 1'b0};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= FETCH;
      fpc   <= RESET_PC;
    end else begin
      state <= next_state;
      fpc   <= fpc_next;
    end
  end

  always_comb begin
    next_state = state;
    fpc_next   = fpc;
    if (flush) begin
      next_state = FETCH;
      fpc_next   = flush_target;
    end else if (enq) begin
      if (bad) next_state = HALT;
      else     fpc_next   = fpc + PC_W'(4);
    end
  end

  ifu_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .push  (enq),
    .wdata (wdata),
    .pop   (deq),
    .rdata (head),
    .count (count)
  );

  assign im_addr      = fpc;
  assign fq.out_pc    = head[EW-1 -: PC_W];
  assign fq.out_instr = head[PC_W:1];
  assign fq.out_exc   = head[0];

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// tb/tb_ifu_fetch_queue.sv - directed vectors plus randomized run against a queue model
module tb_ifu_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, int_req, eret, redirect_valid;
  logic [31:0] epc, redirect_pc, im_addr, im_rdata;
  logic [2:0]  count;

  ifu_fetch_queue_if #(.PC_W(32)) fq_if ();

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return {a[15:0] ^ 16'h5a5a, ~a[31:16]};
  endfunction

  assign im_rdata = imem(im_addr);

  ifu_fetch_queue #(.PC_W(32), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .int_req        (int_req),
    .eret           (eret),
    .epc            (epc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .im_addr        (im_addr),
    .im_rdata       (im_rdata),
    .fq             (fq_if),
    .count          (count)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exc;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_fpc;
  bit          m_halt;
  bit          m_ok = 0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [31:0] pc);
    return (pc % 4 == 0) && (pc >= 32'h3000) && ((pc - 32'h3000) < 32'd16384);
  endfunction

  task automatic model_check();
    bit flush;
    flush = int_req | eret | redirect_valid;
    chk("m_count", 32'(count), 32'(mq.size()));
    chk("m_valid", 32'(fq_if.out_valid), 32'((mq.size() != 0) && !flush));
    chk("m_im_addr", im_addr, m_fpc);
    if (mq.size() != 0) begin
      chk("m_pc", fq_if.out_pc, mq[0].pc);
      chk("m_instr", fq_if.out_instr, mq[0].instr);
      chk("m_exc", 32'(fq_if.out_exc), 32'(mq[0].exc));
    end
  endtask

  task automatic model_step();
    bit   deq, can;
    ent_t e;
    if (!reset) begin
      mq.delete();
      m_fpc  = 32'h3000;
      m_halt = 0;
      m_ok   = 1;
    end else if (int_req || eret || redirect_valid) begin
      mq.delete();
      m_fpc  = int_req ? 32'h4180 : (eret ? epc : redirect_pc);
      m_halt = 0;
    end else begin
      deq = (mq.size() != 0) && fq_if.out_ready;
      can = !m_halt && ((mq.size() < DEPTH) || deq);
      if (deq) void'(mq.pop_front());
      if (can) begin
        if (legal(m_fpc)) begin
          e = '{m_fpc, imem(m_fpc), 1'b0};
          m_fpc = m_fpc + 32'd4;
        end else begin
          e = '{m_fpc, 32'h0, 1'b1};
          m_halt = 1;
        end
        mq.push_back(e);
      end
    end
  endtask

  task automatic tick(input bit rs, input bit ir, input bit er, input logic [31:0] ep,
                      input bit rv, input logic [31:0] rp, input bit rdy);
    @(negedge clk);
    reset = rs; int_req = ir; eret = er; epc = ep;
    redirect_valid = rv; redirect_pc = rp; fq_if.out_ready = rdy;
    #1;
    if (m_ok) model_check();
    model_step();
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 9))
      0:       return 32'h3000 + 4 * $urandom_range(0, 255) + $urandom_range(1, 3);
      1:       return 32'h6ff0 + 4 * $urandom_range(0, 5);
      2:       return 32'h2ffc;
      3:       return 32'hffff_fff8;
      default: return 32'h3000 + 4 * $urandom_range(0, 1023);
    endcase
  endfunction

  typedef struct {
    bit          rs, ir, er, rv;
    logic [31:0] rpc;
    bit          rdy, chkd, valid;
    int          cnt;
    logic [31:0] im, pc;
    bit          exc;
  } vec_t;

  vec_t v[$];

  initial begin
    v.push_back('{0,0,0,0,0,1,0,0,0,0,0,0});
    v.push_back('{0,0,0,0,0,0,1,0,0,'h3000,0,0});
    v.push_back('{1,0,0,0,0,0,1,0,0,'h3000,0,0});
    v.push_back('{1,0,0,0,0,0,1,1,1,'h3004,'h3000,0});
    v.push_back('{1,0,0,0,0,0,1,1,2,'h3008,'h3000,0});
    v.push_back('{1,0,0,0,0,0,1,1,3,'h300c,'h3000,0});
    v.push_back('{1,0,0,0,0,0,1,1,4,'h3010,'h3000,0});
    v.push_back('{1,0,0,0,0,0,1,1,4,'h3010,'h3000,0});
    v.push_back('{1,0,0,0,0,0,1,1,4,'h3010,'h3000,0});
    v.push_back('{1,0,0,0,0,1,1,1,4,'h3010,'h3000,0});
    v.push_back('{1,0,0,0,0,1,1,1,4,'h3014,'h3004,0});
    v.push_back('{1,0,0,0,0,1,1,1,4,'h3018,'h3008,0});
    v.push_back('{1,0,0,0,0,1,1,1,4,'h301c,'h300c,0});
    v.push_back('{1,0,0,0,0,1,1,1,4,'h3020,'h3010,0});
    v.push_back('{1,0,0,1,'h3020,1,1,0,4,'h3024,'h3014,0});
    v.push_back('{1,0,0,0,0,0,1,0,0,'h3020,0,0});
    v.push_back('{1,0,0,0,0,0,1,1,1,'h3024,'h3020,0});
    v.push_back('{1,0,0,0,0,0,1,1,2,'h3028,'h3020,0});
    v.push_back('{1,0,0,1,'h3100,1,1,0,3,'h302c,'h3020,0});
    v.push_back('{1,0,0,0,0,1,1,0,0,'h3100,0,0});
    v.push_back('{1,0,0,0,0,1,1,1,1,'h3104,'h3100,0});
    v.push_back('{1,1,1,0,0,1,1,0,1,'h3108,'h3104,0});
    v.push_back('{1,0,0,0,0,1,1,0,0,'h4180,0,0});
    v.push_back('{1,0,1,0,0,1,1,0,1,'h4184,'h4180,0});
    v.push_back('{1,0,0,0,0,1,1,0,0,'h3040,0,0});
    v.push_back('{1,0,0,0,0,1,1,1,1,'h3044,'h3040,0});
    v.push_back('{1,0,0,1,'h3002,0,1,0,1,'h3048,'h3044,0});
    v.push_back('{1,0,0,0,0,0,1,0,0,'h3002,0,0});
    v.push_back('{1,0,0,0,0,0,1,1,1,'h3002,'h3002,1});
    v.push_back('{1,0,0,0,0,1,1,1,1,'h3002,'h3002,1});
    v.push_back('{1,0,0,0,0,1,1,0,0,'h3002,0,0});
    v.push_back('{1,0,0,1,'h3000,1,1,0,0,'h3002,0,0});
    v.push_back('{1,0,0,0,0,1,1,0,0,'h3000,0,0});
    v.push_back('{1,0,0,0,0,1,1,1,1,'h3004,'h3000,0});
    v.push_back('{1,0,0,0,0,0,1,1,1,'h3008,'h3004,0});
    v.push_back('{1,0,0,0,0,0,1,1,2,'h300c,'h3004,0});
    v.push_back('{1,0,0,0,0,0,1,1,3,'h3010,'h3004,0});
    v.push_back('{1,0,0,0,0,0,1,1,4,'h3014,'h3004,0});
    v.push_back('{0,0,0,1,'h3100,0,1,0,4,'h3014,'h3004,0});
    v.push_back('{1,0,0,0,0,1,1,0,0,'h3000,0,0});
    v.push_back('{1,0,0,0,0,1,1,1,1,'h3004,'h3000,0});
    v.push_back('{1,0,0,0,0,1,1,1,1,'h3008,'h3004,0});
    v.push_back('{1,0,0,0,0,1,1,1,1,'h300c,'h3008,0});

    for (int i = 0; i < v.size(); i++) begin
      tick(v[i].rs, v[i].ir, v[i].er, 32'h3040, v[i].rv, v[i].rpc, v[i].rdy);
      if (v[i].chkd) begin
        chk($sformatf("v%0d_valid", i), 32'(fq_if.out_valid), 32'(v[i].valid));
        chk($sformatf("v%0d_count", i), 32'(count), 32'(v[i].cnt));
        chk($sformatf("v%0d_im_addr", i), im_addr, v[i].im);
        if (v[i].cnt != 0) begin
          chk($sformatf("v%0d_pc", i), fq_if.out_pc, v[i].pc);
          chk($sformatf("v%0d_exc", i), 32'(fq_if.out_exc), 32'(v[i].exc));
          chk($sformatf("v%0d_instr", i), fq_if.out_instr, v[i].exc ? 32'h0 : imem(v[i].pc));
        end
      end
    end

    for (int n = 0; n < 3000; n++) begin
      tick($urandom_range(0, 99) != 0,
           $urandom_range(0, 39) == 0,
           $urandom_range(0, 39) == 0,
           pick_addr(),
           $urandom_range(0, 9) == 0,
           pick_addr(),
           $urandom_range(0, 9) < 7);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifu_fetch_queue.md
# ifu_fetch_queue

Parametrised instruction-fetch unit for the pipelined CPU: owns the fetch PC, reads the instruction memory combinationally, and buffers fetched `{pc, instr, exc}` entries in a small FIFO so decode stalls no longer freeze the PC. Handles branch/jump redirect, interrupt entry and `eret` return by flushing the queue. Flags misaligned or out-of-range fetches as AdEL. Sits between the instruction memory and the D stage, replacing the single PC register.

## Interface
- `PC_W`, 32: PC / instruction width.
- `DEPTH`, 4: queue entries; power of two, ≥2.
- `RESET_PC`, 32'h0000_3000: fetch address after reset.
- `EXC_ENTRY`, 32'h0000_4180: fetch address on interrupt.
- `IM_BASE`, 32'h0000_3000: first legal fetch address.
- `IM_WORDS`, 4096: legal fetch range is `IM_BASE` … `IM_BASE+4*IM_WORDS-4`.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low; state cleared on a rising edge of `clk` while `reset==0`.
- `int_req` in 1: take interrupt; redirect to `EXC_ENTRY`.
- `eret` in 1: return from exception; redirect to `epc`.
- `epc` in `PC_W`: return address.
- `redirect_valid` in 1: branch/jump resolved in D.
- `redirect_pc` in `PC_W`: branch/jump target.
- `im_addr` out `PC_W`: byte address to IM; equals fetch PC.
- `im_rdata` in `PC_W`: instruction at `im_addr`, same cycle.
- `out_valid` out 1: head entry valid.
- `out_ready` in 1: D stage accepts head.
- `out_pc`, `out_instr` out `PC_W`: head entry.
- `out_exc` out 1: head entry is an AdEL fetch.
- `count` out `$clog2(DEPTH)+1`: occupied entries.

## Operation
- State: fetch PC `fpc`, FSM {FETCH, HALT}, FIFO of `DEPTH` entries.
- Flush = `int_req | eret | redirect_valid`. Priority: `int_req` > `eret` > `redirect_valid`. On flush: FIFO emptied (`count` ← 0), `fpc` ← target, FSM ← FETCH, no enqueue and no dequeue that cycle, `out_valid` forced 0.
- Dequeue when `out_valid & out_ready`.
- Enqueue in FETCH when no flush and (`count<DEPTH` or dequeue this cycle): entry `{fpc, im_rdata, 0}`, `fpc` ← `fpc+4`.
- Bad fetch when `fpc[1:0]!=0` or `fpc` is outside the legal range. If the enqueue condition also holds, the unit enqueues `{fpc, 32'h0, 1}`, leaves `fpc` unchanged and sets FSM ← HALT.
- HALT: no enqueue; FIFO drains normally. The FSM leaves HALT only on flush or reset.
- `fpc+4` wraps modulo 2^`PC_W`; the wrapped address is caught by the range check.
- `out_valid = (count!=0) & ~flush`. Head fields are the FIFO head regardless of `out_valid`.
- Simultaneous enqueue and dequeue at full: both take effect; `count` is unchanged.

## Timing
- Reset (`reset==0` at an edge): `fpc=RESET_PC`, FSM=FETCH, `count=0`, `out_valid=0`, `im_addr=RESET_PC`. A flush in the same cycle is ignored.
- First entry is visible (`out_valid=1`, `out_pc=RESET_PC`) in the cycle after the first edge with `reset==1`.
- Redirect latency: flush sampled at edge N; the target entry is valid after edge N+1, so `out_valid` is low for one cycle.
- Throughput: one enqueue and one dequeue per cycle, sustained.
- `count`, `out_*` (except the flush gating of `out_valid`) are registered or FIFO-read outputs. `im_addr` is a register output.
- Reset mid-operation discards all entries within one edge.

## Structure
- Package `ifu_pkg`: exception code `EXC_ADEL=5'd4`, default `RESET_PC`/`EXC_ENTRY`, and the FSM state enum.
- Sub-module `ifu_fifo`: generic circular buffer (parameters width and depth), with synchronous clear input for flush and wrap-around read/write pointers.
- Top-level: fetch FSM, range check, flush priority mux.

## Test plan
- Reset release, `out_ready=1` held: `out_pc` = 0x3000, 0x3004, 0x3008 … on consecutive cycles, `out_exc=0`.
- `out_ready=0` for 10 cycles, `DEPTH=4`: `count` saturates at 4; `im_addr` holds at 0x3010. Set `out_ready=1`: in-order drain with no gaps.
- `redirect_valid` with target 0x3100 while the queue holds 3 entries: `out_valid=0` next cycle, then head `out_pc=0x3100`, `count=1`.
- `int_req` and `eret` (epc 0x3040) in the same cycle: target 0x4180 wins. Next, `eret` alone with epc 0x3040 resumes fetch at 0x3040.
- Redirect to 0x3002: one entry `{0x3002, 0, exc=1}`, then no further enqueue. A redirect to 0x3000 resumes normal fetch.
- `reset=0` asserted while full and `redirect_valid=1`: the following cycle has `count=0` and `im_addr=0x3000`.
